// File: rtl/mem_access_if.sv
// Byte-wide memory port between the MEM stage and data RAM.
// Read data on ram_din is valid one cycle after its address is presented.
interface mem_access_if;
  logic [31:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;

  modport master (output ram_addr, output ram_dout, output ram_wr, input ram_din);
  modport slave  (input ram_addr, input ram_dout, input ram_wr, output ram_din);
endinterface

// File: rtl/mem_access.sv
// MEM pipeline stage: serialises LB/LH/LW/LBU/LHU/SB/SH/SW into byte accesses
// over a byte-wide RAM port, stalling the pipeline until the access completes.
module mem_access (
  input  logic                clk,
  input  logic                rst,
  mem_access_if.master        ram,
  input  logic [4:0]          mem_wd,
  input  logic                mem_wreg,
  input  logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_mem_addr,
  input  logic [7:0]          mem_aluop,
  output logic                stallreq,
  output logic [4:0]          wb_wd,
  output logic                wb_wreg,
  output logic [31:0]         wb_wdata
);

  localparam logic [7:0] ME_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] ME_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] ME_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] ME_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] ME_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] ME_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] ME_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] ME_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_next;
  logic [1:0]  cnt, cnt_next;
  logic [31:0] buffer, buffer_next;

  logic        is_load, is_store;
  logic [1:0]  len_code;   // access length modulo 4 (LW/SW -> 0)
  logic        last;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    len_code = 2'd1;
    case (mem_aluop)
      ME_LB_OP, ME_LBU_OP: begin is_load  = 1'b1; len_code = 2'd1; end
      ME_LH_OP, ME_LHU_OP: begin is_load  = 1'b1; len_code = 2'd2; end
      ME_LW_OP:            begin is_load  = 1'b1; len_code = 2'd0; end
      ME_SB_OP:            begin is_store = 1'b1; len_code = 2'd1; end
      ME_SH_OP:            begin is_store = 1'b1; len_code = 2'd2; end
      ME_SW_OP:            begin is_store = 1'b1; len_code = 2'd0; end
      default:             ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      buffer <= 32'd0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      buffer <= buffer_next;
    end
  end

  // NOTE: every output and next-state variable gets a default first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    buffer_next  = buffer;
    ram.ram_addr = 32'd0;
    ram.ram_dout = 8'd0;
    ram.ram_wr   = 1'b0;
    stallreq     = 1'b0;
    wb_wd        = 5'd0;
    wb_wreg      = 1'b0;
    wb_wdata     = 32'd0;
    last         = (cnt == len_code);

    case (state)
      IDLE: begin
        if (is_load || is_store) begin
          stallreq     = 1'b1;
          ram.ram_addr = mem_mem_addr;
          buffer_next  = 32'd0;
          cnt_next     = 2'd1;
          if (is_store) begin
            ram.ram_wr   = 1'b1;
            ram.ram_dout = mem_wdata[7:0];
          end
          // A single-byte store finishes in its issue cycle.
          state_next = (is_store && len_code == 2'd1) ? DONE : BUSY;
        end else begin
          wb_wd    = mem_wd;
          wb_wreg  = mem_wreg;
          wb_wdata = mem_wdata;
        end
      end

      BUSY: begin
        stallreq = 1'b1;
        cnt_next = cnt + 2'd1;
        if (is_load) begin
          // Byte returned this cycle belongs to the address issued last cycle.
          buffer_next[{2'(cnt - 2'd1), 3'b000} +: 8] = ram.ram_din;
          if (last) begin
            state_next = DONE;
          end else begin
            ram.ram_addr = mem_mem_addr + {30'd0, cnt};
          end
        end else if (is_store) begin
          ram.ram_addr = mem_mem_addr + {30'd0, cnt};
          ram.ram_wr   = 1'b1;
          ram.ram_dout = mem_wdata[{cnt, 3'b000} +: 8];
          if (cnt == 2'(len_code - 2'd1)) state_next = DONE;
        end else begin
          stallreq   = 1'b0;
          state_next = IDLE;
          cnt_next   = 2'd0;
        end
      end

      DONE: begin
        state_next = IDLE;
        cnt_next   = 2'd0;
        wb_wd      = mem_wd;
        wb_wreg    = is_store ? 1'b0 : mem_wreg;
        case (mem_aluop)
          ME_LB_OP:  wb_wdata = {{24{buffer[7]}}, buffer[7:0]};
          ME_LBU_OP: wb_wdata = {24'd0, buffer[7:0]};
          ME_LH_OP:  wb_wdata = {{16{buffer[15]}}, buffer[15:0]};
          ME_LHU_OP: wb_wdata = {16'd0, buffer[15:0]};
          ME_LW_OP:  wb_wdata = buffer;
          default:   wb_wdata = 32'd0;
        endcase
      end

      default: begin
        state_next = IDLE;
        cnt_next   = 2'd0;
      end
    endcase

    // Reset silences every output in the same cycle, aborting any access.
    if (!rst) begin
      ram.ram_addr = 32'd0;
      ram.ram_dout = 8'd0;
      ram.ram_wr   = 1'b0;
      stallreq     = 1'b0;
      wb_wd        = 5'd0;
      wb_wreg      = 1'b0;
      wb_wdata     = 32'd0;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: byte-addressed RAM model, table of operations with a
// scoreboard of expected write-back results, plus reset and re-execution sequences.
module tb_mem_access;

  localparam logic [7:0] OP_NOP = 8'h00, OP_ALU = 8'h21;
  localparam logic [7:0] OP_LB  = 8'hE0, OP_LH  = 8'hE1, OP_LW = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4, OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8, OP_SH  = 8'hE9, OP_SW = 8'hEB;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  mem_wd = '0;
  logic        mem_wreg = 1'b0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_mem_addr = '0;
  logic [7:0]  mem_aluop = OP_NOP;
  logic        stallreq;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;

  mem_access_if ram ();

  mem_access dut (
    .clk          (clk),
    .rst          (rst),
    .ram          (ram),
    .mem_wd       (mem_wd),
    .mem_wreg     (mem_wreg),
    .mem_wdata    (mem_wdata),
    .mem_mem_addr (mem_mem_addr),
    .mem_aluop    (mem_aluop),
    .stallreq     (stallreq),
    .wb_wd        (wb_wd),
    .wb_wreg      (wb_wreg),
    .wb_wdata     (wb_wdata)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous write, read data returned one cycle later.
  typedef struct { logic [31:0] addr; logic [7:0] data; } wr_t;
  logic [7:0] mem [logic [31:0]];
  wr_t        wlog [$];

  initial ram.ram_din = 8'h00;
  always @(posedge clk) begin
    if (ram.ram_wr === 1'b1) begin
      mem[ram.ram_addr] = ram.ram_dout;
      wlog.push_back('{ram.ram_addr, ram.ram_dout});
    end
    ram.ram_din <= mem.exists(ram.ram_addr) ? mem[ram.ram_addr] : 8'h00;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
    logic        pre_en;
    logic [31:0] pre;       // little-endian bytes preloaded at addr
    int          len;
    logic        is_store;
    logic [31:0] exp_wdata;
    int          exp_stall;
  } vec_t;

  typedef struct { logic [4:0] wd; logic wreg; logic [31:0] wdata; int stall; } exp_t;
  exp_t sb [$];

  task automatic run_op(input vec_t v);
    exp_t        e;
    exp_t        got;
    int          stalls;
    logic        side_bad;
    logic [31:0] addrs [$];
    e.wd    = v.wd;
    e.wreg  = v.is_store ? 1'b0 : v.wreg;
    e.wdata = v.exp_wdata;
    e.stall = v.exp_stall;
    if (v.pre_en)
      for (int k = 0; k < v.len; k++) mem[v.addr + 32'(k)] = v.pre[8*k +: 8];
    @(posedge clk);
    #1;
    wlog.delete();
    mem_aluop    = v.op;
    mem_mem_addr = v.addr;
    mem_wdata    = v.wdata;
    mem_wd       = v.wd;
    mem_wreg     = v.wreg;
    sb.push_back(e);
    stalls   = 0;
    side_bad = 1'b0;
    @(negedge clk);
    while (stallreq === 1'b1 && stalls < 12) begin
      addrs.push_back(ram.ram_addr);
      if (wb_wreg !== 1'b0 || wb_wdata !== 32'd0 || wb_wd !== 5'd0) side_bad = 1'b1;
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 12) begin
      check({v.name, "_timeout"}, 32'(stalls), 32'(v.exp_stall));
      void'(sb.pop_front());
    end else begin
      got = sb.pop_front();
      check({v.name, "_stall"},   32'(stalls),  32'(got.stall));
      check({v.name, "_wb_wd"},   32'(wb_wd),   32'(got.wd));
      check({v.name, "_wb_wreg"}, 32'(wb_wreg), 32'(got.wreg));
      check({v.name, "_wb_wdata"}, wb_wdata,    got.wdata);
      check({v.name, "_done_wr"}, 32'(ram.ram_wr), 32'd0);
      if (stalls > 0) check({v.name, "_quiet_wb"}, 32'(side_bad), 32'd0);
      if (v.op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU})
        for (int k = 0; k < v.len && k < addrs.size(); k++)
          check($sformatf("%s_addr%0d", v.name, k), addrs[k], v.addr + 32'(k));
    end
    @(posedge clk);
    #1;
    mem_aluop = OP_NOP;
    check({v.name, "_nwr"}, 32'(wlog.size()), v.is_store ? 32'(v.len) : 32'd0);
    if (v.is_store)
      for (int k = 0; k < wlog.size() && k < v.len; k++) begin
        check($sformatf("%s_wa%0d", v.name, k), wlog[k].addr, v.addr + 32'(k));
        check($sformatf("%s_wd%0d", v.name, k), 32'(wlog[k].data), 32'(v.wdata[8*k +: 8]));
      end
  endtask

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{"nop",   OP_NOP, 32'h0,        32'h12345678, 5'd3, 1'b1, 1'b0, 32'h0,        1, 1'b0, 32'h12345678, 0};
    vecs[1]  = '{"lw",    OP_LW,  32'h100,      32'h0,        5'd4, 1'b1, 1'b1, 32'h12345678, 4, 1'b0, 32'h12345678, 5};
    vecs[2]  = '{"lb",    OP_LB,  32'h200,      32'h0,        5'd5, 1'b1, 1'b1, 32'h00000080, 1, 1'b0, 32'hFFFFFF80, 2};
    vecs[3]  = '{"lbu",   OP_LBU, 32'h200,      32'h0,        5'd6, 1'b1, 1'b0, 32'h0,        1, 1'b0, 32'h00000080, 2};
    vecs[4]  = '{"lh",    OP_LH,  32'h300,      32'h0,        5'd7, 1'b1, 1'b1, 32'h0000F001, 2, 1'b0, 32'hFFFFF001, 3};
    vecs[5]  = '{"lhu",   OP_LHU, 32'h300,      32'h0,        5'd8, 1'b1, 1'b0, 32'h0,        2, 1'b0, 32'h0000F001, 3};
    vecs[6]  = '{"sh",    OP_SH,  32'h400,      32'hAABBCCDD, 5'd9, 1'b1, 1'b0, 32'h0,        2, 1'b1, 32'h0,        2};
    vecs[7]  = '{"sb",    OP_SB,  32'h500,      32'h11223344, 5'd10, 1'b1, 1'b0, 32'h0,       1, 1'b1, 32'h0,        1};
    vecs[8]  = '{"sw_wrap", OP_SW, 32'hFFFFFFFE, 32'hCAFEBABE, 5'd11, 1'b1, 1'b0, 32'h0,      4, 1'b1, 32'h0,        4};
    vecs[9]  = '{"lw_wrap", OP_LW, 32'hFFFFFFFE, 32'h0,        5'd12, 1'b1, 1'b0, 32'h0,      4, 1'b0, 32'hCAFEBABE, 5};
    vecs[10] = '{"alu",   OP_ALU, 32'h0,        32'hDEADBEEF, 5'd13, 1'b0, 1'b0, 32'h0,       1, 1'b0, 32'hDEADBEEF, 0};

    // Reset with a load on the inputs: everything must stay at zero.
    rst          = 1'b0;
    mem_aluop    = OP_LW;
    mem_mem_addr = 32'h100;
    mem_wd       = 5'd1;
    mem_wreg     = 1'b1;
    mem_wdata    = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall",   32'(stallreq), 32'd0);
    check("rst_ram",     32'(|{ram.ram_addr, ram.ram_dout, ram.ram_wr}), 32'd0);
    check("rst_wb",      32'(|{wb_wd, wb_wreg, wb_wdata}), 32'd0);
    @(posedge clk);
    #1;
    mem_aluop = OP_NOP;
    rst       = 1'b1;

    for (int i = 0; i < 11; i++) run_op(vecs[i]);

    // SH must not touch the byte after its two.
    check("sh_402_untouched", 32'(mem.exists(32'h402)), 32'd0);

    // Reset asserted in cycle 2 of an SW aborts after two bytes.
    @(posedge clk);
    #1;
    wlog.delete();
    mem_aluop    = OP_SW;
    mem_mem_addr = 32'h600;
    mem_wdata    = 32'h44332211;
    mem_wd       = 5'd2;
    mem_wreg     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_wr",    32'(ram.ram_wr), 32'd0);
    check("abort_outs",  32'(|{ram.ram_addr, ram.ram_dout, stallreq, wb_wd, wb_wreg, wb_wdata}), 32'd0);
    @(posedge clk);
    #1;
    mem_aluop = OP_NOP;
    @(posedge clk);
    #1;
    check("abort_nwr", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      check("abort_w0", {wlog[0].addr[23:0], wlog[0].data}, 32'h00060011);
      check("abort_w1", {wlog[1].addr[23:0], wlog[1].data}, 32'h00060122);
    end
    check("abort_no_602", 32'(mem.exists(32'h602)), 32'd0);

    // First cycle after release is IDLE: an LB issues its own address at once.
    rst          = 1'b1;
    mem_aluop    = OP_LB;
    mem_mem_addr = 32'h200;
    mem_wd       = 5'd14;
    @(negedge clk);
    check("post_rst_stall", 32'(stallreq), 32'd1);
    check("post_rst_addr",  ram.ram_addr, 32'h200);
    begin
      int guard = 0;
      while (stallreq === 1'b1 && guard < 10) begin
        guard++;
        @(negedge clk);
      end
      check("post_rst_cycles", 32'(guard), 32'd2);
    end
    check("post_rst_lb", wb_wdata, 32'hFFFFFF80);
    @(posedge clk);
    #1;
    mem_aluop = OP_NOP;

    // An SB held past DONE is executed again from IDLE.
    @(posedge clk);
    #1;
    wlog.delete();
    mem_aluop    = OP_SB;
    mem_mem_addr = 32'h700;
    mem_wdata    = 32'h0000005A;
    @(negedge clk);
    check("reexec_c0_stall", 32'(stallreq), 32'd1);
    @(negedge clk);
    check("reexec_done_stall", 32'(stallreq), 32'd0);
    @(negedge clk);
    check("reexec_again", {ram.ram_addr[15:0], 7'd0, ram.ram_wr, 7'd0, stallreq}, 32'h07000101);
    @(posedge clk);
    #1;
    mem_aluop = OP_NOP;
    check("reexec_nwr", 32'(wlog.size()), 32'd2);
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
